// File: rtl/dropout_grad_replay.sv
// dropout_grad_replay
// Backward-pass replay of forward dropout masks. Forward side pushes 8-bit
// masks onto a LIFO so they come back in reverse layer order. Backward side
// streams 8 signed gradient bytes per vector (neuron 0..7). Each byte is
// zeroed when its neuron was dropped, otherwise shifted left by SCALE_SHIFT
// with signed saturation to 8 bits.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   ena               global enable; low freezes state and blocks handshakes
//   fwd_valid/ready   mask push handshake, fwd_mask = kept-neuron bitmap
//   bwd_valid/ready   gradient byte handshake, bwd_grad = signed byte
//   out_valid/ready   result handshake, out_data = masked/scaled gradient,
//                     out_idx = neuron index of out_data
//   depth_cnt         number of masks currently stored
//
// state  | meaning
// IDLE   | no vector in progress; next accepted byte pops a mask
// ACTIVE | vector in progress; idx is the next expected neuron index
module dropout_grad_replay #(
  parameter int DEPTH       = 4,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     fwd_valid,
  input  logic [7:0]               fwd_mask,
  output logic                     fwd_ready,
  input  logic                     bwd_valid,
  input  logic [7:0]               bwd_grad,
  output logic                     bwd_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [2:0]               out_idx,
  output logic [$clog2(DEPTH):0]   depth_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [7:0]    stack_mem [DEPTH];
  logic [CW-1:0] count;
  state_t        state;
  logic [2:0]    idx;
  logic [7:0]    act_mask;

  logic          slot_free;
  logic          push;
  logic          accept;
  logic          pop;
  logic [AW-1:0] top_addr;
  logic [AW-1:0] wr_addr;
  logic [7:0]    cur_mask;
  logic [2:0]    cur_idx;
  logic          keep;

  logic signed [10:0] grad_wide;
  logic signed [10:0] grad_shl;
  logic [7:0]         grad_sat;

  assign slot_free = !out_valid || out_ready;
  assign fwd_ready = ena && (count != CW'(DEPTH));
  assign bwd_ready = ena && slot_free && ((state == ACTIVE) || (count != '0));
  assign depth_cnt = count;

  assign push   = fwd_valid && fwd_ready;
  assign accept = bwd_valid && bwd_ready;
  assign pop    = accept && (state == IDLE);

  // On a simultaneous push and pop the new mask replaces the popped top
  // slot, so the stack height is unchanged and the popped value is the old top.
  assign top_addr = AW'(count - CW'(1));
  assign wr_addr  = pop ? top_addr : AW'(count);

  // The first byte of a vector uses the freshly popped mask directly.
  assign cur_mask = pop ? stack_mem[top_addr] : act_mask;
  assign cur_idx  = pop ? 3'd0 : idx;
  assign keep     = cur_mask[cur_idx];

  // 11 bits holds +/-128 << 3 without overflow, so the clamp sees the true value.
  assign grad_wide = 11'($signed(bwd_grad));
  assign grad_shl  = grad_wide <<< SCALE_SHIFT;

  always_comb begin
    grad_sat = grad_shl[7:0];
    if (grad_shl > 11'sd127)
      grad_sat = 8'h7F;
    else if (grad_shl < -11'sd128)
      grad_sat = 8'h80;
  end

  // Stack storage carries no reset; its contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (push)
      stack_mem[wr_addr] <= fwd_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      state     <= IDLE;
      idx       <= 3'd0;
      act_mask  <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_idx   <= 3'd0;
    end else if (ena) begin
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);

      if (accept) begin
        out_valid <= 1'b1;
        out_idx   <= cur_idx;
        out_data  <= keep ? grad_sat : 8'h00;
        if (pop)
          act_mask <= cur_mask;
        if (cur_idx == 3'd7) begin
          state <= IDLE;
          idx   <= 3'd0;
        end else begin
          state <= ACTIVE;
          idx   <= cur_idx + 3'd1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dropout_grad_replay.sv
module tb_dropout_grad_replay;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       fwd_valid;
  logic [7:0] fwd_mask;
  logic       fwd_ready;
  logic       bwd_valid;
  logic [7:0] bwd_grad;
  logic       bwd_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [2:0] depth_cnt;

  always #5 clk = ~clk;

  dropout_grad_replay #(.DEPTH(4), .SCALE_SHIFT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .fwd_valid (fwd_valid),
    .fwd_mask  (fwd_mask),
    .fwd_ready (fwd_ready),
    .bwd_valid (bwd_valid),
    .bwd_grad  (bwd_grad),
    .bwd_ready (bwd_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .depth_cnt (depth_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {idx, data} per accepted byte, in acceptance order.
  logic [10:0] sb[$];
  logic [2:0]  exp_idx;
  logic [7:0]  exp_data;

  // Byte 0 of grads/exps is the leftmost byte of the 64-bit literal.
  typedef struct packed {
    logic [7:0]  mask;
    logic [63:0] grads;
    logic [63:0] exps;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic logic [7:0] byte_of(input logic [63:0] w, input int i);
    return w[63-8*i -: 8];
  endfunction

  // Scoreboard monitor: inputs only change just after posedge, so the
  // negedge view is what the next posedge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready && ena) begin
        if (sb.size() == 0) begin
          fail("unexpected_output");
        end else begin
          logic [10:0] e;
          e = sb.pop_front();
          check("out_data", {24'h0, out_data}, {24'h0, e[7:0]});
          check("out_idx", {29'h0, out_idx}, {29'h0, e[10:8]});
        end
      end
      if (bwd_valid && bwd_ready)
        sb.push_back({exp_idx, exp_data});
    end
  end

  task automatic set_byte(input logic [7:0] g, input logic [2:0] ei, input logic [7:0] ed);
    bwd_valid = 1'b1;
    bwd_grad  = g;
    exp_idx   = ei;
    exp_data  = ed;
  endtask

  task automatic send_byte(input logic [7:0] g, input logic [2:0] ei, input logic [7:0] ed);
    int n = 0;
    set_byte(g, ei, ed);
    @(negedge clk);
    while (!bwd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bwd_ready) fail("bwd_accept_timeout");
    @(posedge clk); #1;
    bwd_valid = 1'b0;
  endtask

  task automatic push_mask(input logic [7:0] m);
    int n = 0;
    fwd_valid = 1'b1;
    fwd_mask  = m;
    @(negedge clk);
    while (!fwd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!fwd_ready) fail("push_timeout");
    @(posedge clk); #1;
    fwd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] m3 [3];

    tbl[0] = '{mask: 8'hA5, grads: 64'h1010_1010_1010_1010, exps: 64'h2000_2000_0020_0020};
    tbl[1] = '{mask: 8'hFF, grads: 64'h50B0_3FC0_7F80_00FF, exps: 64'h7F80_7E80_7F80_00FE};
    tbl[2] = '{mask: 8'h0F, grads: 64'h01F0_40C1_0506_0708, exps: 64'h02E0_7F82_0000_0000};
    tbl[3] = '{mask: 8'h5A, grads: 64'h817E_0102_FE3F_4000, exps: 64'h007F_0004_FC00_7F00};

    rst_n = 1'b0; ena = 1'b1;
    fwd_valid = 1'b0; fwd_mask = 8'h00;
    bwd_valid = 1'b0; bwd_grad = 8'h00;
    out_ready = 1'b1; exp_idx = 3'd0; exp_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data", {24'h0, out_data}, 32'h0);
    check("rst_out_idx", {29'h0, out_idx}, 32'h0);
    check("rst_depth", {29'h0, depth_cnt}, 32'h0);
    check("rst_fwd_ready", {31'h0, fwd_ready}, 32'h1);
    check("rst_bwd_ready", {31'h0, bwd_ready}, 32'h0);
    rst_n = 1'b1;

    // Single push then one full vector per table entry.
    for (int v = 0; v < 4; v++) begin
      push_mask(tbl[v].mask);
      check("tbl_depth_push", {29'h0, depth_cnt}, 32'h1);
      for (int i = 0; i < 8; i++) begin
        send_byte(byte_of(tbl[v].grads, i), 3'(i), byte_of(tbl[v].exps, i));
        if (i == 0) check("tbl_depth_pop", {29'h0, depth_cnt}, 32'h0);
      end
      drain();
    end

    // Fill the stack, verify full behaviour, replay in LIFO order.
    push_mask(8'h01);
    push_mask(8'h02);
    push_mask(8'h03);
    push_mask(8'hFF);
    check("full_depth", {29'h0, depth_cnt}, 32'h4);
    check("full_fwd_ready", {31'h0, fwd_ready}, 32'h0);
    fwd_valid = 1'b1; fwd_mask = 8'hEE;
    repeat (2) begin
      @(negedge clk);
      check("full_no_ready", {31'h0, fwd_ready}, 32'h0);
    end
    @(posedge clk); #1;
    fwd_valid = 1'b0;
    check("full_no_overwrite", {29'h0, depth_cnt}, 32'h4);
    m3[0] = 8'hFF; m3[1] = 8'h03; m3[2] = 8'h02;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 8; i++)
        send_byte(8'h01, 3'(i), m3[v][i] ? 8'h02 : 8'h00);
      drain();
    end
    for (int i = 0; i < 8; i++)
      send_byte(8'h01, 3'(i), (i == 0) ? 8'h02 : 8'h00);
    drain();
    check("lifo_empty", {29'h0, depth_cnt}, 32'h0);

    // Backpressure: first output held for 5 cycles with next byte pending.
    push_mask(8'hFF);
    out_ready = 1'b0;
    send_byte(8'h11, 3'd0, 8'h22);
    set_byte(8'h22, 3'd1, 8'h44);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_out_data", {24'h0, out_data}, 32'h22);
      check("bp_out_idx", {29'h0, out_idx}, 32'h0);
      check("bp_bwd_ready", {31'h0, bwd_ready}, 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_byte(8'h22, 3'd1, 8'h44);
    send_byte(8'h33, 3'd2, 8'h66);
    send_byte(8'h44, 3'd3, 8'h7F);
    send_byte(8'h55, 3'd4, 8'h7F);
    send_byte(8'h66, 3'd5, 8'h7F);
    send_byte(8'h77, 3'd6, 8'h7F);
    send_byte(8'h08, 3'd7, 8'h10);
    drain();

    // Empty stack stalls the backward side until a mask arrives.
    set_byte(tbl[2].grads[63:56], 3'd0, tbl[2].exps[63:56]);
    repeat (10) begin
      @(negedge clk);
      check("empty_stall", {31'h0, bwd_ready}, 32'h0);
    end
    @(posedge clk); #1;
    push_mask(8'h0F);
    @(negedge clk);
    check("empty_release", {31'h0, bwd_ready}, 32'h1);
    @(posedge clk); #1;
    bwd_valid = 1'b0;
    for (int i = 1; i < 8; i++)
      send_byte(byte_of(tbl[2].grads, i), 3'(i), byte_of(tbl[2].exps, i));
    drain();

    // Simultaneous push and pop at count=2.
    push_mask(8'h3C);
    push_mask(8'h81);
    fwd_valid = 1'b1; fwd_mask = 8'h33;
    set_byte(8'h01, 3'd0, 8'h02);
    @(negedge clk);
    check("pp_fwd_ready", {31'h0, fwd_ready}, 32'h1);
    check("pp_bwd_ready", {31'h0, bwd_ready}, 32'h1);
    @(posedge clk); #1;
    fwd_valid = 1'b0; bwd_valid = 1'b0;
    check("pp_depth", {29'h0, depth_cnt}, 32'h2);
    for (int i = 1; i < 8; i++)
      send_byte(8'h01, 3'(i), (i == 7) ? 8'h02 : 8'h00);
    drain();
    send_byte(8'h01, 3'd0, 8'h02);
    send_byte(8'h01, 3'd1, 8'h02);
    send_byte(8'h01, 3'd2, 8'h00);
    check("pp_depth_after", {29'h0, depth_cnt}, 32'h1);

    // Freeze with ena=0 mid-vector.
    ena = 1'b0;
    set_byte(8'h01, 3'd3, 8'h00);
    repeat (3) begin
      @(negedge clk);
      check("ena_bwd_ready", {31'h0, bwd_ready}, 32'h0);
      check("ena_fwd_ready", {31'h0, fwd_ready}, 32'h0);
      check("ena_out_valid", {31'h0, out_valid}, 32'h1);
      check("ena_out_idx", {29'h0, out_idx}, 32'h2);
      check("ena_depth", {29'h0, depth_cnt}, 32'h1);
    end
    @(posedge clk); #1;
    ena = 1'b1;
    send_byte(8'h01, 3'd3, 8'h00);
    send_byte(8'h01, 3'd4, 8'h02);

    // Reset mid-vector with an output pending.
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_pending", sb.size(), 32'h1);
    sb.delete();
    check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_depth", {29'h0, depth_cnt}, 32'h0);
    check("mid_rst_out_idx", {29'h0, out_idx}, 32'h0);
    check("mid_rst_out_data", {24'h0, out_data}, 32'h0);
    check("mid_rst_bwd_ready", {31'h0, bwd_ready}, 32'h0);
    rst_n = 1'b1;
    push_mask(8'h80);
    for (int i = 0; i < 8; i++)
      send_byte(8'h01, 3'(i), (i == 7) ? 8'h02 : 8'h00);
    drain();
    check("final_depth", {29'h0, depth_cnt}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
